// File: rtl/bp_pkg.sv
// Shared types and constants for the branch resolve queue.
// Entry layout: {pc, pred_taken, pred_target}.
package bp_pkg;

  localparam int BP_DEPTH    = 8;
  localparam int BP_PTR_BITS = 3;
  localparam int INSN_BYTES  = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic        pred_taken;
    logic [31:0] pred_target;
  } bp_entry_t;

endpackage

// File: rtl/bp_entry_fifo.sv
// Circular buffer of in-flight predictions with pointers and count.
// Ports: clk, rst_n (sync, active-high), clear, push/wdata, pop/rdata, full, empty.
module bp_entry_fifo
  import bp_pkg::*;
#(
  parameter int DEPTH    = BP_DEPTH,
  parameter int PTR_BITS = BP_PTR_BITS
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      clear,
  input  logic      push,
  input  bp_entry_t wdata,
  input  logic      pop,
  output bp_entry_t rdata,
  output logic      full,
  output logic      empty
);

  localparam logic [PTR_BITS:0] FULL_CNT =
    (PTR_BITS+1)'(DEPTH);

  bp_entry_t           mem [DEPTH];
  logic [PTR_BITS-1:0] wr_ptr;
  logic [PTR_BITS-1:0] rd_ptr;
  logic [PTR_BITS:0]   count;
  logic                do_push;
  logic                do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst_n || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Contents need no reset; pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/branch_resolve_queue.sv
// In-order prediction queue: compares outcome vs prediction, drives flush and BTB update.
// Ports: push side (pc/pred), resolve side (taken/target), flush/redirect, BTB update, stats.
module branch_resolve_queue
  import bp_pkg::*;
#(
  parameter int DEPTH    = BP_DEPTH,
  parameter int PTR_BITS = BP_PTR_BITS,
  parameter int CNT_BITS = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                push,
  input  logic [31:0]         push_pc,
  input  logic                push_pred_taken,
  input  logic [31:0]         push_pred_target,
  output logic                full,
  output logic                empty,
  input  logic                resolve_valid,
  input  logic                resolve_taken,
  input  logic [31:0]         resolve_target,
  output logic                flush,
  output logic [31:0]         redirect_pc,
  output logic                branch_update,
  output logic                branch_taken,
  output logic [31:0]         target_addr,
  output logic [31:0]         update_pc,
  output logic [CNT_BITS-1:0] mispredict_count,
  output logic                underflow_err
);

  bp_entry_t   wdata;
  bp_entry_t   head;
  logic        res_ok;
  logic        mis;
  logic [31:0] next_pc;

  assign wdata = '{pc:          push_pc,
                   pred_taken:  push_pred_taken,
                   pred_target: push_pred_target};

  assign res_ok = resolve_valid && !empty;

  assign mis = res_ok &&
    ((head.pred_taken != resolve_taken) ||
     (resolve_taken &&
      head.pred_target != resolve_target));

  assign next_pc = resolve_taken ? resolve_target
                 : head.pc + 32'(INSN_BYTES);

  // A mispredict clears the queue, which also
  // discards any push arriving in the same cycle.
  bp_entry_fifo #(
    .DEPTH    (DEPTH),
    .PTR_BITS (PTR_BITS)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (mis),
    .push  (push),
    .wdata (wdata),
    .pop   (res_ok),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (rst_n) begin
      flush            <= 1'b0;
      redirect_pc      <= '0;
      branch_update    <= 1'b0;
      branch_taken     <= 1'b0;
      target_addr      <= '0;
      update_pc        <= '0;
      mispredict_count <= '0;
      underflow_err    <= 1'b0;
    end else begin
      flush         <= mis;
      branch_update <= res_ok;
      if (res_ok) begin
        branch_taken <= resolve_taken;
        target_addr  <= resolve_target;
        update_pc    <= head.pc;
      end
      if (mis) begin
        redirect_pc <= next_pc;
        if (mispredict_count != '1)
          mispredict_count <= mispredict_count + 1'b1;
      end
      if (resolve_valid && empty)
        underflow_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed self-checking bench for branch_resolve_queue.
// Inputs change 1ns after rising edges; outputs are checked there too.
module tb_branch_resolve_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        push;
  logic [31:0] push_pc;
  logic        push_pred_taken;
  logic [31:0] push_pred_target;
  logic        full;
  logic        empty;
  logic        resolve_valid;
  logic        resolve_taken;
  logic [31:0] resolve_target;
  logic        flush;
  logic [31:0] redirect_pc;
  logic        branch_update;
  logic        branch_taken;
  logic [31:0] target_addr;
  logic [31:0] update_pc;
  logic [15:0] mispredict_count;
  logic        underflow_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  branch_resolve_queue dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .push             (push),
    .push_pc          (push_pc),
    .push_pred_taken  (push_pred_taken),
    .push_pred_target (push_pred_target),
    .full             (full),
    .empty            (empty),
    .resolve_valid    (resolve_valid),
    .resolve_taken    (resolve_taken),
    .resolve_target   (resolve_target),
    .flush            (flush),
    .redirect_pc      (redirect_pc),
    .branch_update    (branch_update),
    .branch_taken     (branch_taken),
    .target_addr      (target_addr),
    .update_pc        (update_pc),
    .mispredict_count (mispredict_count),
    .underflow_err    (underflow_err)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_push(input logic [31:0] pc,
                         input logic        pt,
                         input logic [31:0] tg);
    push             = 1'b1;
    push_pc          = pc;
    push_pred_taken  = pt;
    push_pred_target = tg;
  endtask

  task automatic do_res(input logic        tk,
                        input logic [31:0] tg);
    resolve_valid  = 1'b1;
    resolve_taken  = tk;
    resolve_target = tg;
  endtask

  task automatic idle();
    push          = 1'b0;
    resolve_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1;
    push = 1'b0; push_pc = '0;
    push_pred_taken = 1'b0; push_pred_target = '0;
    resolve_valid = 1'b0; resolve_taken = 1'b0;
    resolve_target = '0;
    #1;
    step(); step();
    rst_n = 1'b0;
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_flush", 32'(flush), 0);
    chk("rst_upd", 32'(branch_update), 0);
    chk("rst_mcnt", 32'(mispredict_count), 0);
    chk("rst_uerr", 32'(underflow_err), 0);

    // correct taken prediction
    do_push(32'h100, 1'b1, 32'h200); step(); idle();
    chk("t1_nonempty", 32'(empty), 0);
    do_res(1'b1, 32'h200); step(); idle();
    chk("t1_upd", 32'(branch_update), 1);
    chk("t1_taken", 32'(branch_taken), 1);
    chk("t1_tgt", target_addr, 32'h200);
    chk("t1_upc", update_pc, 32'h100);
    chk("t1_flush", 32'(flush), 0);
    chk("t1_empty", 32'(empty), 1);
    step();
    chk("t1_upd_pulse", 32'(branch_update), 0);
    chk("t1_hold_upc", update_pc, 32'h100);

    // direction mispredict
    do_push(32'h100, 1'b1, 32'h200); step();
    do_push(32'h104, 1'b0, 32'h0); step(); idle();
    do_res(1'b0, 32'h0); step(); idle();
    chk("t2_flush", 32'(flush), 1);
    chk("t2_redir", redirect_pc, 32'h104);
    chk("t2_mcnt", 32'(mispredict_count), 1);
    chk("t2_empty", 32'(empty), 1);
    step();
    chk("t2_flush_pulse", 32'(flush), 0);

    // target mispredict
    do_push(32'h300, 1'b1, 32'h400); step(); idle();
    do_res(1'b1, 32'h480); step(); idle();
    chk("t3_flush", 32'(flush), 1);
    chk("t3_redir", redirect_pc, 32'h480);
    chk("t3_tgt", target_addr, 32'h480);
    chk("t3_mcnt", 32'(mispredict_count), 2);

    // fill, overflow push, drain in order
    for (int i = 0; i < 8; i++) begin
      do_push(32'h1000 + 32'(i*4), 1'b0, 32'h0);
      step();
    end
    chk("t4_full", 32'(full), 1);
    do_push(32'hDEAD0, 1'b0, 32'h0); step(); idle();
    chk("t4_full_hold", 32'(full), 1);
    for (int i = 0; i < 8; i++) begin
      do_res(1'b0, 32'h0); step();
      chk("t4_upc", update_pc, 32'h1000 + 32'(i*4));
      chk("t4_noflush", 32'(flush), 0);
    end
    idle();
    chk("t4_empty", 32'(empty), 1);
    for (int i = 0; i < 3; i++) begin
      do_push(32'h2000 + 32'(i*4), 1'b0, 32'h0);
      step(); idle();
      do_res(1'b0, 32'h0); step(); idle();
      chk("t4_wrap_upc", update_pc, 32'h2000 + 32'(i*4));
    end
    chk("t4_wrap_empty", 32'(empty), 1);
    chk("t4_mcnt", 32'(mispredict_count), 2);

    // underflow
    step();
    do_res(1'b1, 32'h55); step(); idle();
    chk("t5_noupd", 32'(branch_update), 0);
    chk("t5_noflush", 32'(flush), 0);
    chk("t5_uerr", 32'(underflow_err), 1);
    step();
    chk("t5_sticky", 32'(underflow_err), 1);

    // push concurrent with mispredicting resolve
    do_push(32'h500, 1'b1, 32'h600); step();
    do_push(32'h504, 1'b0, 32'h0);
    do_res(1'b0, 32'h0); step(); idle();
    chk("t6_flush", 32'(flush), 1);
    chk("t6_redir", redirect_pc, 32'h504);
    chk("t6_empty", 32'(empty), 1);
    chk("t6_mcnt", 32'(mispredict_count), 3);

    // push concurrent with correct resolve
    do_push(32'h700, 1'b0, 32'h0); step();
    do_push(32'h704, 1'b0, 32'h0);
    do_res(1'b0, 32'h0); step(); idle();
    chk("t7_upd", 32'(branch_update), 1);
    chk("t7_upc", update_pc, 32'h700);
    chk("t7_flush", 32'(flush), 0);
    chk("t7_nonempty", 32'(empty), 0);
    do_res(1'b0, 32'h0); step(); idle();
    chk("t7_upc2", update_pc, 32'h704);
    chk("t7_empty", 32'(empty), 1);

    // reset mid-operation
    do_push(32'h800, 1'b1, 32'h900); step(); idle();
    rst_n = 1'b1; step(); rst_n = 1'b0;
    chk("t8_empty", 32'(empty), 1);
    chk("t8_uerr", 32'(underflow_err), 0);
    chk("t8_mcnt", 32'(mispredict_count), 0);
    do_res(1'b0, 32'h0); step(); idle();
    chk("t8_noupd", 32'(branch_update), 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_resolve_queue.md
Name: branch_resolve_queue

Overview:
- In-order queue of in-flight branch predictions, between the fetch-stage BTB lookup and the execute-stage branch unit.
- Fetch pushes each predicted branch. Execute resolves branches oldest-first.
- The block compares prediction against outcome and produces:
  - a registered flush/redirect to fetch;
  - the update strobe, taken flag, target and PC consumed by the BTB write port.

Parameters:
- DEPTH, 8: number of in-flight prediction entries; power of two, at least 2.
- PTR_BITS, 3: log2(DEPTH).
- CNT_BITS, 16: width of the mispredict statistics counter.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  reset, synchronous, active-high: rst_n=1 resets on the next rising edge of clk.
- push  in  1  fetch enqueues a branch prediction this cycle.
- push_pc  in  32  PC of the fetched branch.
- push_pred_taken  in  1  BTB hit, treated as a predicted-taken branch.
- push_pred_target  in  32  BTB target (btb_target).
- full  out  1  count==DEPTH; fetch must stall branch fetch.
- empty  out  1  count==0.
- resolve_valid  in  1  execute resolves the oldest branch.
- resolve_taken  in  1  actual direction.
- resolve_target  in  32  actual target address.
- flush  out  1  one-cycle mispredict pulse to fetch and decode.
- redirect_pc  out  32  correct next PC; valid while flush=1.
- branch_update  out  1  one-cycle BTB write strobe.
- branch_taken  out  1  actual direction, to the BTB.
- target_addr  out  32  actual target, to the BTB.
- update_pc  out  32  PC of the resolved branch; fetch muxes it onto the BTB pc input while branch_update=1.
- mispredict_count  out  CNT_BITS  saturating mispredict counter.
- underflow_err  out  1  sticky: resolve_valid arrived while the queue was empty.

Behaviour:
- Storage
  - Circular buffer of DEPTH entries {pc, pred_taken, pred_target}.
  - wr_ptr and rd_ptr are PTR_BITS wide and wrap modulo DEPTH.
  - count is PTR_BITS+1 bits.
- Reset
  - Clears wr_ptr, rd_ptr and count.
  - All outputs 0, except empty=1.
  - Entry contents are don't-care.
  - Reset mid-operation discards all entries; no update or flush is emitted for them.
- Push
  - Accepted when push=1 && !full && !mispredict_this_cycle.
  - When full, push is dropped silently; no state change.
- Resolve
  - Accepted when resolve_valid=1 && !empty. It pops the entry at rd_ptr.
  - Mispredict = (pred_taken != resolve_taken) || (resolve_taken && pred_target != resolve_target).
  - Correct next PC = resolve_taken ? resolve_target : pc+4, modulo 2^32.
- Resolve outputs (registered, one cycle after the accepted resolve)
  - branch_update=1 for every accepted resolve.
  - branch_taken, target_addr and update_pc carry the resolve values and the entry PC.
  - On mispredict: flush=1, redirect_pc = correct next PC, mispredict_count increments and saturates at all-ones.
  - flush and branch_update are single-cycle pulses. They are 0, and data outputs hold their last values, when no resolve was accepted.
- Flush handling
  - In the resolve cycle that mispredicts, all younger entries are wrong-path: rd_ptr=wr_ptr=0, count=0.
  - A push in that same cycle is discarded.
- Simultaneous push and resolve, no mispredict
  - Count is unchanged; both pointers advance.
  - Allowed when not full, and also when full=0 from count<DEPTH.
  - When full, the push is dropped even if a pop occurs that cycle (full is decided on registered count).
- Underflow
  - resolve_valid with empty=1 is ignored: no update, no flush.
  - underflow_err sets to 1 and is cleared only by reset.
- Status timing: full and empty are combinational from registered count, so they reflect the state after the previous edge.

Decomposition:
- Shared package bp_pkg holds:
  - constants BP_DEPTH=8, BP_PTR_BITS=3, INSN_BYTES=4;
  - the entry struct/typedef {pc[31:0], pred_taken, pred_target[31:0]}.
- One sub-module is natural: bp_entry_fifo (storage, pointers, count, full/empty, clear input).
- The top level holds the compare, redirect, update and statistics logic.

Test Plan:
- Reset: rst_n=1 for 2 cycles, then 0 -> empty=1, full=0, flush=0, branch_update=0, mispredict_count=0, underflow_err=0.
- Correct taken prediction: push pc=0x100, pred_taken=1, target=0x200; resolve taken=1, target=0x200 -> next cycle branch_update=1, branch_taken=1, target_addr=0x200, update_pc=0x100, flush=0.
- Direction mispredict:
  - Push pc=0x100 pred_taken=1 target=0x200, then push pc=0x104.
  - Resolve the first with taken=0 -> next cycle flush=1, redirect_pc=0x104, mispredict_count=1, empty=1 (pc=0x104 entry discarded).
- Target mispredict: push pc=0x300 pred_taken=1 target=0x400; resolve taken=1 target=0x480 -> flush=1, redirect_pc=0x480, target_addr=0x480.
- Full and wrap:
  - 8 pushes -> full=1; 9th push ignored.
  - 8 in-order resolves return pc values in push order; then 3 more push/resolve pairs wrap the pointers correctly.
- Underflow and simultaneous events:
  - resolve_valid on empty -> no branch_update, underflow_err=1 and sticky.
  - Push concurrent with a mispredicting resolve -> empty=1 after the edge.
  - Push concurrent with a correct resolve -> count unchanged.
